// File: rtl/instr_decoder_if.sv
// rtl/instr_decoder_if.sv - fetch-side and controller-side signal bundle of the decode stage
interface instr_decoder_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic             out_valid;
  logic             out_ready;
  logic [30:0]      out_code;
  logic [4:0]       out_rs;
  logic [4:0]       out_rt;
  logic [4:0]       out_rd;
  logic [4:0]       out_shamt;
  logic [15:0]      out_imm16;
  logic [25:0]      out_index;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_cnt;
  logic             clr_cnt;

  modport master (
    output in_valid, in_instr, out_ready, clr_cnt,
    input  in_ready, out_valid, out_code, out_rs, out_rt, out_rd,
           out_shamt, out_imm16, out_index, out_illegal, illegal_cnt
  );

  modport slave (
    input  in_valid, in_instr, out_ready, clr_cnt,
    output in_ready, out_valid, out_code, out_rs, out_rt, out_rd,
           out_shamt, out_imm16, out_index, out_illegal, illegal_cnt
  );
endinterface

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - registered MIPS decode stage producing the one-hot opcode bus
module instr_decoder #(
  parameter int CNT_W = 16
) (
  input logic            clk,
  input logic            rst,
  instr_decoder_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [5:0]       op;
  logic [5:0]       funct;
  logic [30:0]      dec_code;
  logic             dec_illegal;
  logic             accept;
  logic             ready;

  logic             valid_q;
  logic [30:0]      code_q;
  logic [4:0]       rs_q;
  logic [4:0]       rt_q;
  logic [4:0]       rd_q;
  logic [4:0]       shamt_q;
  logic [15:0]      imm16_q;
  logic [25:0]      index_q;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q;

  assign op    = bus.in_instr[31:26];
  assign funct = bus.in_instr[5:0];

  // Only op and funct select the opcode; the remaining fields pass through untouched.
  always_comb begin
    dec_code = '0;
    if (op == OP_RTYPE) begin
      case (funct)
        6'h20:   dec_code[0]  = 1'b1;
        6'h21:   dec_code[1]  = 1'b1;
        6'h22:   dec_code[2]  = 1'b1;
        6'h23:   dec_code[3]  = 1'b1;
        6'h24:   dec_code[4]  = 1'b1;
        6'h25:   dec_code[5]  = 1'b1;
        6'h26:   dec_code[6]  = 1'b1;
        6'h27:   dec_code[7]  = 1'b1;
        6'h2A:   dec_code[8]  = 1'b1;
        6'h2B:   dec_code[9]  = 1'b1;
        6'h00:   dec_code[10] = 1'b1;
        6'h02:   dec_code[11] = 1'b1;
        6'h03:   dec_code[12] = 1'b1;
        6'h04:   dec_code[13] = 1'b1;
        6'h06:   dec_code[14] = 1'b1;
        6'h07:   dec_code[15] = 1'b1;
        6'h08:   dec_code[16] = 1'b1;
        default: dec_code     = '0;
      endcase
    end else begin
      case (op)
        OP_ADDI:  dec_code[17] = 1'b1;
        OP_ADDIU: dec_code[18] = 1'b1;
        OP_ANDI:  dec_code[19] = 1'b1;
        OP_ORI:   dec_code[20] = 1'b1;
        OP_XORI:  dec_code[21] = 1'b1;
        OP_LW:    dec_code[22] = 1'b1;
        OP_SW:    dec_code[23] = 1'b1;
        OP_BEQ:   dec_code[24] = 1'b1;
        OP_BNE:   dec_code[25] = 1'b1;
        OP_SLTI:  dec_code[26] = 1'b1;
        OP_SLTIU: dec_code[27] = 1'b1;
        OP_LUI:   dec_code[28] = 1'b1;
        OP_J:     dec_code[29] = 1'b1;
        OP_JAL:   dec_code[30] = 1'b1;
        default:  dec_code     = '0;
      endcase
    end
  end

  assign dec_illegal = (dec_code == '0);

  assign ready  = ~valid_q | bus.out_ready;
  assign accept = bus.in_valid & ready;

  // An accept overwrites the held entry even while it is being popped, giving one word per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      code_q    <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      shamt_q   <= '0;
      imm16_q   <= '0;
      index_q   <= '0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      valid_q   <= 1'b1;
      code_q    <= dec_code;
      rs_q      <= bus.in_instr[25:21];
      rt_q      <= bus.in_instr[20:16];
      rd_q      <= bus.in_instr[15:11];
      shamt_q   <= bus.in_instr[10:6];
      imm16_q   <= bus.in_instr[15:0];
      index_q   <= bus.in_instr[25:0];
      illegal_q <= dec_illegal;
    end else if (valid_q && bus.out_ready) begin
      valid_q   <= 1'b0;
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (bus.clr_cnt) begin
      cnt_q <= '0;
    end else if (accept && dec_illegal && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign bus.in_ready    = ready;
  assign bus.out_valid   = valid_q;
  assign bus.out_code    = code_q;
  assign bus.out_rs      = rs_q;
  assign bus.out_rt      = rt_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_shamt   = shamt_q;
  assign bus.out_imm16   = imm16_q;
  assign bus.out_index   = index_q;
  assign bus.out_illegal = illegal_q;
  assign bus.illegal_cnt = cnt_q;

endmodule

// File: tb/tb_instr_decoder.sv
// tb/tb_instr_decoder.sv - directed checks of the decode stage with hand-computed expectations
module tb_instr_decoder;

  logic clk;
  logic rst;

  int checks;
  int errors;

  instr_decoder_if #(.CNT_W(16)) bus_a ();
  instr_decoder_if #(.CNT_W(2))  bus_b ();

  instr_decoder #(.CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  instr_decoder #(.CNT_W(2))  dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] code;
    string       name;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{32'h00000022, 32'h1 << 2,  "sub"};
    vecs[1] = '{32'h00000027, 32'h1 << 7,  "nor"};
    vecs[2] = '{32'h00000007, 32'h1 << 15, "srav"};
    vecs[3] = '{32'h03E00008, 32'h1 << 16, "jr"};
    vecs[4] = '{32'hAC000000, 32'h1 << 23, "sw"};
    vecs[5] = '{32'h3C000000, 32'h1 << 28, "lui"};
    vecs[6] = '{32'h08000000, 32'h1 << 29, "j"};
    vecs[7] = '{32'h2C000000, 32'h1 << 27, "sltiu"};
    vecs[8] = '{32'h0000002B, 32'h1 << 9,  "sltu"};
    vecs[9] = '{32'h14000000, 32'h1 << 25, "bne"};
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_instr = '0; bus_a.out_ready = 1'b1; bus_a.clr_cnt = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_instr = '0; bus_b.out_ready = 1'b1; bus_b.clr_cnt = 1'b0;
    #12;
    check("rst_valid",   {31'b0, bus_a.out_valid},   32'h0);
    check("rst_code",    {1'b0, bus_a.out_code},     32'h0);
    check("rst_illegal", {31'b0, bus_a.out_illegal}, 32'h0);
    check("rst_cnt",     {16'b0, bus_a.illegal_cnt}, 32'h0);
    check("rst_index",   {6'b0, bus_a.out_index},    32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", {31'b0, bus_a.in_ready}, 32'h1);

    // add $8,$9,$10
    bus_a.in_instr = 32'h012A4020; bus_a.in_valid = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    check("add_valid",   {31'b0, bus_a.out_valid},   32'h1);
    check("add_code",    {1'b0, bus_a.out_code},     32'h1);
    check("add_rs",      {27'b0, bus_a.out_rs},      32'd9);
    check("add_rt",      {27'b0, bus_a.out_rt},      32'd10);
    check("add_rd",      {27'b0, bus_a.out_rd},      32'd8);
    check("add_illegal", {31'b0, bus_a.out_illegal}, 32'h0);
    tick();
    check("pop_valid", {31'b0, bus_a.out_valid}, 32'h0);
    check("pop_hold",  {1'b0, bus_a.out_code},   32'h1);

    // back-to-back stream
    bus_a.in_instr = 32'h8D090004; bus_a.in_valid = 1'b1;
    tick();
    check("lw_code",  {1'b0, bus_a.out_code},    32'h1 << 22);
    check("lw_imm",   {16'b0, bus_a.out_imm16},  32'h0004);
    bus_a.in_instr = 32'h11090003;
    tick();
    check("beq_code",  {1'b0, bus_a.out_code},   32'h1 << 24);
    check("beq_imm",   {16'b0, bus_a.out_imm16}, 32'h0003);
    check("beq_valid", {31'b0, bus_a.out_valid}, 32'h1);
    bus_a.in_instr = 32'h0C000010;
    tick();
    check("jal_code",  {1'b0, bus_a.out_code},   32'h1 << 30);
    check("jal_index", {6'b0, bus_a.out_index},  32'h0000010);
    bus_a.in_valid = 1'b0;
    tick();

    // stall: ori held while addiu waits
    bus_a.out_ready = 1'b0;
    bus_a.in_instr = 32'h3508FFFF; bus_a.in_valid = 1'b1;
    tick();
    bus_a.in_instr = 32'h25080001;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_ready", {31'b0, bus_a.in_ready},  32'h0);
      check("stall_code",  {1'b0, bus_a.out_code},   32'h1 << 20);
      check("stall_imm",   {16'b0, bus_a.out_imm16}, 32'hFFFF);
      check("stall_valid", {31'b0, bus_a.out_valid}, 32'h1);
      tick();
    end
    bus_a.out_ready = 1'b1;
    #1;
    check("release_ready", {31'b0, bus_a.in_ready}, 32'h1);
    tick();
    bus_a.in_valid = 1'b0;
    check("addiu_code", {1'b0, bus_a.out_code},  32'h1 << 18);
    check("addiu_imm",  {16'b0, bus_a.out_imm16}, 32'h0001);
    tick();
    check("drain_valid", {31'b0, bus_a.out_valid}, 32'h0);

    // illegal words and the all-zero word
    bus_a.in_instr = 32'hFC000000; bus_a.in_valid = 1'b1;
    tick();
    check("ill1_code",    {1'b0, bus_a.out_code},     32'h0);
    check("ill1_illegal", {31'b0, bus_a.out_illegal}, 32'h1);
    check("ill1_cnt",     {16'b0, bus_a.illegal_cnt}, 32'd1);
    bus_a.in_instr = 32'h01200001;
    tick();
    check("ill2_code",    {1'b0, bus_a.out_code},     32'h0);
    check("ill2_illegal", {31'b0, bus_a.out_illegal}, 32'h1);
    check("ill2_rs",      {27'b0, bus_a.out_rs},      32'd9);
    check("ill2_cnt",     {16'b0, bus_a.illegal_cnt}, 32'd2);
    bus_a.in_instr = 32'h00000000;
    tick();
    check("zero_code",    {1'b0, bus_a.out_code},     32'h1 << 10);
    check("zero_illegal", {31'b0, bus_a.out_illegal}, 32'h0);
    check("zero_cnt",     {16'b0, bus_a.illegal_cnt}, 32'd2);
    bus_a.in_instr = 32'h00000140;
    tick();
    check("sll_code",  {1'b0, bus_a.out_code},   32'h1 << 10);
    check("sll_shamt", {27'b0, bus_a.out_shamt}, 32'd5);

    foreach (vecs[k]) begin
      bus_a.in_instr = vecs[k].instr;
      tick();
      check(vecs[k].name, {1'b0, bus_a.out_code}, vecs[k].code);
    end
    bus_a.in_valid = 1'b0;
    tick();

    // saturating counter on the 2-bit instance
    bus_b.in_instr = 32'hFFFFFFFF; bus_b.in_valid = 1'b1;
    tick(); check("sat_1", {30'b0, bus_b.illegal_cnt}, 32'd1);
    tick(); check("sat_2", {30'b0, bus_b.illegal_cnt}, 32'd2);
    tick(); check("sat_3", {30'b0, bus_b.illegal_cnt}, 32'd3);
    tick(); check("sat_4", {30'b0, bus_b.illegal_cnt}, 32'd3);
    tick(); check("sat_5", {30'b0, bus_b.illegal_cnt}, 32'd3);
    bus_b.clr_cnt = 1'b1;
    tick(); check("clr_prio", {30'b0, bus_b.illegal_cnt}, 32'd0);
    bus_b.clr_cnt = 1'b0; bus_b.in_valid = 1'b0;
    tick();

    // asynchronous reset while stalled
    bus_a.out_ready = 1'b0;
    bus_a.in_instr = 32'h3508FFFF; bus_a.in_valid = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    check("pre_rst_valid", {31'b0, bus_a.out_valid},   32'h1);
    check("pre_rst_cnt",   {16'b0, bus_a.illegal_cnt}, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("async_valid", {31'b0, bus_a.out_valid},   32'h0);
    check("async_cnt",   {16'b0, bus_a.illegal_cnt}, 32'd0);
    check("async_code",  {1'b0, bus_a.out_code},     32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'b0, bus_a.in_ready}, 32'h1);
    tick();
    check("post_rst_valid", {31'b0, bus_a.out_valid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
